// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for one shared, fixed-latency registered adder.
// Grants one requester per cycle, issues its operands to the adder and carries
// the requester ID through a tag pipe so each result returns with its owner.
module adder_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDER_LAT = 1,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    output logic                      add_valid,
    input  logic [DATA_W:0]           add_sum,
    input  logic                      add_valid_out,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W:0]           rsp_sum,
    output logic                      tag_err
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic            accept;

    // Stage 0 mirrors add_valid; stage ADDER_LAT lines up with add_valid_out.
    logic            tag_v  [0:ADDER_LAT];
    logic [ID_W-1:0] tag_id [0:ADDER_LAT];

    // Round-robin search starting at rr_ptr; the first hit wins, so at most one grant.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        cand      = '0;
        accept    = 1'b0;
        if (!rst && en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!accept && req_valid[cand]) begin
                    accept          = 1'b1;
                    req_ready[cand] = 1'b1;
                    grant_idx       = cand;
                end
            end
        end
    end

    // Issue register and pointer advance; operands hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            add_valid <= accept;
            if (accept) begin
                add_a  <= req_a[grant_idx*DATA_W +: DATA_W];
                add_b  <= req_b[grant_idx*DATA_W +: DATA_W];
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Tag pipe: shifts every edge regardless of traffic, matching the adder latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= ADDER_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= grant_idx;
            for (int k = 1; k <= ADDER_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Response capture and sticky mismatch flag; responses still flow after an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            tag_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (add_valid_out && tag_v[ADDER_LAT]) begin
                rsp_valid <= 1'b1;
                rsp_id    <= tag_id[ADDER_LAT];
                rsp_sum   <= add_sum;
            end
            if (add_valid_out != tag_v[ADDER_LAT])
                tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios plus random traffic, checked
// against a queue-based model of grants and tagged responses.
module tb_adder_rr_scheduler;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AL = 1;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [DW-1:0]    add_a;
    logic [DW-1:0]    add_b;
    logic             add_valid;
    logic [DW:0]      add_sum;
    logic             add_valid_out;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW:0]      rsp_sum;
    logic             tag_err;

    logic             inj = 1'b0;
    logic             adder_v;
    logic [DW:0]      adder_s;

    adder_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ADDER_LAT(AL)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
        .add_sum(add_sum), .add_valid_out(add_valid_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Single-stage adder, reset together with the scheduler; inj forces a stray result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_v <= 1'b0;
            adder_s <= '0;
        end else begin
            adder_v <= add_valid;
            adder_s <= {1'b0, add_a} + {1'b0, add_b};
        end
    end
    assign add_valid_out = adder_v | inj;
    assign add_sum       = adder_s;

    typedef struct {
        int due;
        int id;
        int sum;
    } rsp_t;

    rsp_t          rq[$];
    int            ptr;
    int            cyc;
    bit            err;
    int            last_id;
    int            last_sum;
    int            last_a;
    int            last_b;
    bit            pend[NR];
    logic [DW-1:0] opa[NR];
    logic [DW-1:0] opb[NR];
    int            passes = 0;
    int            total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = pend[i];
            req_a[i*DW +: DW]    = opa[i];
            req_b[i*DW +: DW]    = opb[i];
        end
    endtask

    task automatic post(input int i, input int a, input int b);
        pend[i] = 1'b1;
        opa[i]  = DW'(a);
        opb[i]  = DW'(b);
    endtask

    task automatic gen(input int pct);
        for (int i = 0; i < NR; i++)
            if (!pend[i] && $urandom_range(99) < pct)
                post(i, $urandom_range(255), $urandom_range(255));
    endtask

    // One clock of traffic: predict the grant, step the edge, check issue and response.
    task automatic cycle();
        int  g;
        bit  tail;
        drive();
        #1;
        g = -1;
        if (en)
            for (int k = 0; k < NR; k++)
                if (g < 0 && pend[(ptr + k) % NR]) g = (ptr + k) % NR;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        tail = (rq.size() > 0) && (rq[0].due == cyc);
        if (inj && !tail) err = 1'b1;
        if (tail) begin
            last_id  = rq[0].id;
            last_sum = rq[0].sum;
            void'(rq.pop_front());
        end
        if (g >= 0) begin
            ptr    = (g + 1) % NR;
            last_a = int'(opa[g]);
            last_b = int'(opb[g]);
            rq.push_back('{cyc + AL + 1, g, int'(opa[g]) + int'(opb[g])});
            pend[g] = 1'b0;
        end
        chk("add_valid", 32'(add_valid), 32'(g >= 0));
        chk("add_a", 32'(add_a), last_a);
        chk("add_b", 32'(add_b), last_b);
        chk("rsp_valid", 32'(rsp_valid), 32'(tail));
        chk("rsp_id", 32'(rsp_id), last_id);
        chk("rsp_sum", 32'(rsp_sum), last_sum);
        chk("tag_err", 32'(tag_err), 32'(err));
        inj = 1'b0;
    endtask

    task automatic model_reset();
        rq.delete();
        ptr = 0; err = 1'b0;
        last_id = 0; last_sum = 0; last_a = 0; last_b = 0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_add_valid"}, 32'(add_valid), 0);
        chk({tag, "_add_a"}, 32'(add_a), 0);
        chk({tag, "_add_b"}, 32'(add_b), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_sum"}, 32'(rsp_sum), 0);
        chk({tag, "_tag_err"}, 32'(tag_err), 0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = '0; end
        // Power-on reset with a request pending: no grant while rst is high.
        post(0, 1, 1);
        en = 1'b1;
        drive();
        #1;
        check_reset_outputs("por");
        pend[0] = 1'b0;
        drive();
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        rst = 1'b0;

        // All four requesters held: grants 0,1,2,3,0,1 back to back.
        for (int n = 0; n < 6; n++) begin
            gen(100);
            cycle();
        end
        repeat (3) cycle();

        // Requester 1 alone, idle pipe.
        post(1, 5, 3);
        drive();
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0010);
        #0;
        cycle();
        cycle();
        cycle();
        chk("t1_sum", 32'(rsp_sum), 8);
        chk("t1_id", 32'(rsp_id), 1);

        // Carry out and pointer wrap 3 -> 0.
        post(3, 255, 255);
        cycle();
        post(0, 200, 100);
        cycle();
        cycle();
        chk("t3_sum510", 32'(rsp_sum), 510);
        cycle();
        chk("t3_sum300", 32'(rsp_sum), 300);
        repeat (2) cycle();

        // Stray adder result with an empty tag pipe, then clean traffic.
        inj = 1'b1;
        cycle();
        chk("t4_err_set", 32'(tag_err), 1);
        for (int n = 0; n < 8; n++) begin gen(60); cycle(); end

        // Continuous traffic with en dropped for three cycles.
        for (int n = 0; n < 4; n++) begin gen(100); cycle(); end
        en = 1'b0;
        for (int n = 0; n < 3; n++) begin gen(100); cycle(); end
        en = 1'b1;
        for (int n = 0; n < 5; n++) begin gen(100); cycle(); end
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;

        // Random traffic with occasional en drops and stray results.
        for (int n = 0; n < 300; n++) begin
            gen(40);
            en  = ($urandom_range(9) != 0);
            inj = ($urandom_range(49) == 0) && (rq.size() == 0);
            cycle();
        end
        en = 1'b1;
        repeat (4) cycle();

        // Reset with two results in flight.
        gen(100);
        cycle();
        gen(100);
        cycle();
        rst = 1'b1;
        model_reset();
        drive();
        #1;
        check_reset_outputs("rst");
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) cycle();
        post(2, 17, 250);
        cycle();
        cycle();
        cycle();
        chk("t6_sum", 32'(rsp_sum), 267);
        chk("t6_id", 32'(rsp_id), 2);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Hard stop in case the run is stalled somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
